// File: rtl/riscy_data_mem_responder_if.sv
// Data-memory bus between the RISCY core (master) and its memory responder (slave).
// Carries the request/grant/response signals; clock, reset and side ports stay on the module.
interface riscy_data_mem_responder_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o
    );
endinterface

// File: rtl/riscy_data_mem_responder.sv
// Word RAM answering the RISCY data port: byte-enable writes, fixed-latency in-order responses,
// stall throttling, backdoor preload and an INIT_VALUE clear sweep. MEM_STATS_EN adds access counters.
module riscy_data_mem_responder #(
    parameter int          MEM_DEPTH_WORDS = 256,
    parameter int          RVALID_LATENCY  = 1,
    parameter logic [31:0] INIT_VALUE      = 32'h0000_0000
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    riscy_data_mem_responder_if.slave          bus,
    input  logic                               stall_i,
    input  logic                               bd_we_i,
    input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] bd_addr_i,
    input  logic [31:0]                        bd_wdata_i,
    input  logic                               mem_clear_i,
    output logic                               busy_o
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]                        rd_count_o,
    output logic [31:0]                        wr_count_o
`endif
);

    localparam int AW = $clog2(MEM_DEPTH_WORDS);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [AW-1:0] r_clrIdx;
    logic        w_busy;

    logic [31:0] r_mem [MEM_DEPTH_WORDS];

    logic          w_gnt;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rdNew;
    logic          w_unusedAddr;

    logic        r_vld [RVALID_LATENCY];
    logic [31:0] r_dat [RVALID_LATENCY];

    assign w_idx        = bus.data_addr_i[AW+1:2];
    assign w_unusedAddr = ^{bus.data_addr_i[31:AW+2], bus.data_addr_i[1:0]};

    assign w_gnt          = bus.data_req_i & ~stall_i & ~w_busy & ~rst_i;
    assign bus.data_gnt_o = w_gnt;
    assign busy_o         = w_busy;

    // Reset suppresses the response outputs immediately so a dropped transaction never surfaces.
    assign bus.data_rvalid_o = r_vld[RVALID_LATENCY-1] & ~rst_i;
    assign bus.data_rdata_o  = rst_i ? 32'h0 : r_dat[RVALID_LATENCY-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_clrIdx <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_clrIdx <= (r_state == S_CLEAR) ? r_clrIdx + 1'b1 : '0;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_clear_i) begin
                    w_stateNext = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_busy = 1'b1;
                if (r_clrIdx == AW'(MEM_DEPTH_WORDS - 1)) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // The bus write comes after the backdoor write so enabled bus lanes override a same-word preload.
    always_ff @(posedge clk_i) begin
        if (w_busy) begin
            r_mem[r_clrIdx] <= INIT_VALUE;
        end else begin
            if (bd_we_i) begin
                r_mem[bd_addr_i] <= bd_wdata_i;
            end
            if (w_gnt && bus.data_we_i) begin
                for (int n = 0; n < 4; n++) begin
                    if (bus.data_be_i[n]) begin
                        r_mem[w_idx][8*n +: 8] <= bus.data_wdata_i[8*n +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdNew = 32'h0;
        if (w_gnt && !bus.data_we_i) begin
            w_rdNew = r_mem[w_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= 32'h0;
            end
        end else begin
            r_vld[0] <= w_gnt;
            r_dat[0] <= w_rdNew;
            for (int i = 1; i < RVALID_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_count_o <= 32'h0;
            wr_count_o <= 32'h0;
        end else if (w_gnt) begin
            if (bus.data_we_i) begin
                wr_count_o <= wr_count_o + 32'd1;
            end else begin
                rd_count_o <= rd_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscy_data_mem_responder.sv
// Directed bench for riscy_data_mem_responder: one instance at latency 1 with a non-zero
// clear value, one at latency 3; both share clock, reset and side-band controls.
module tb_riscy_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        bdWe = 1'b0;
    logic [7:0]  bdAddr = 8'h0;
    logic [31:0] bdWdata = 32'h0;
    logic        memClear = 1'b0;
    logic        busy1;
    logic        busy3;

    int testsRun = 0;
    int testsFailed = 0;

    riscy_data_mem_responder_if bus1 ();
    riscy_data_mem_responder_if bus3 ();

`ifdef MEM_STATS_EN
    logic [31:0] rdCount1, wrCount1, rdCount3, wrCount3;
`endif

    riscy_data_mem_responder #(
        .MEM_DEPTH_WORDS(256),
        .RVALID_LATENCY (1),
        .INIT_VALUE     (32'hA5A5_A5A5)
    ) u1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus1),
        .stall_i    (stall),
        .bd_we_i    (bdWe),
        .bd_addr_i  (bdAddr),
        .bd_wdata_i (bdWdata),
        .mem_clear_i(memClear),
        .busy_o     (busy1)
`ifdef MEM_STATS_EN
        ,
        .rd_count_o (rdCount1),
        .wr_count_o (wrCount1)
`endif
    );

    riscy_data_mem_responder #(
        .MEM_DEPTH_WORDS(256),
        .RVALID_LATENCY (3),
        .INIT_VALUE     (32'h0000_0000)
    ) u3 (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus3),
        .stall_i    (stall),
        .bd_we_i    (bdWe),
        .bd_addr_i  (bdAddr),
        .bd_wdata_i (bdWdata),
        .mem_clear_i(memClear),
        .busy_o     (busy3)
`ifdef MEM_STATS_EN
        ,
        .rd_count_o (rdCount3),
        .wr_count_o (wrCount3)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleBuses();
        bus1.data_req_i   = 1'b0;
        bus1.data_we_i    = 1'b0;
        bus1.data_be_i    = 4'hF;
        bus1.data_addr_i  = 32'h0;
        bus1.data_wdata_i = 32'h0;
        bus3.data_req_i   = 1'b0;
        bus3.data_we_i    = 1'b0;
        bus3.data_be_i    = 4'hF;
        bus3.data_addr_i  = 32'h0;
        bus3.data_wdata_i = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        bus1.data_req_i = 1'b1;
        #1;
        testsRun++;
        if (bus1.data_gnt_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_gnt got %b want 0", bus1.data_gnt_o);
        end
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b0 || bus1.data_rdata_o !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_resp got rvalid=%b rdata=%h want 0/0", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
        testsRun++;
        if (busy1 !== 1'b0 || bus3.data_rvalid_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy got busy=%b rvalid3=%b want 0/0", busy1, bus3.data_rvalid_o);
        end
        bus1.data_req_i = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_basic();
        bdWe = 1'b1; bdAddr = 8'd5; bdWdata = 32'hDEAD_BEEF;
        tick();
        bdWe = 1'b0;
        bus1.data_req_i = 1'b1; bus1.data_we_i = 1'b0; bus1.data_addr_i = 32'h14;
        #1;
        testsRun++;
        if (bus1.data_gnt_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL read_gnt got %b want 1", bus1.data_gnt_o);
        end
        tick();
        bus1.data_req_i = 1'b0;
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b1 || bus1.data_rdata_o !== 32'hDEAD_BEEF) begin
            testsFailed++;
            $display("[TB] FAIL read_resp got rvalid=%b rdata=%h want 1/deadbeef", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
        tick();
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b0 || bus1.data_rdata_o !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL read_idle got rvalid=%b rdata=%h want 0/0", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
    endtask

    task automatic test_byte_write();
        bdWe = 1'b1; bdAddr = 8'd3; bdWdata = 32'h1122_3344;
        tick();
        bdWe = 1'b0;
        bus1.data_req_i = 1'b1; bus1.data_we_i = 1'b1; bus1.data_addr_i = 32'h0C;
        bus1.data_be_i = 4'b0101; bus1.data_wdata_i = 32'hAABB_CCDD;
        tick();
        bus1.data_we_i = 1'b0; bus1.data_be_i = 4'hF; bus1.data_wdata_i = 32'h0;
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b1 || bus1.data_rdata_o !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL write_resp got rvalid=%b rdata=%h want 1/0", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
        tick();
        bus1.data_req_i = 1'b0;
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b1 || bus1.data_rdata_o !== 32'h11BB_33DD) begin
            testsFailed++;
            $display("[TB] FAIL byte_merge got rvalid=%b rdata=%h want 1/11bb33dd", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic        expVld;
        logic [31:0] expDat;
        for (int w = 0; w < 3; w++) begin
            bdWe = 1'b1; bdAddr = 8'(w); bdWdata = 32'(w + 1);
            tick();
        end
        bdWe = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus3.data_req_i  = (k < 3);
            bus3.data_we_i   = 1'b0;
            bus3.data_addr_i = 32'(k * 4);
            tick();
            expVld = (k >= 2 && k <= 4);
            expDat = expVld ? 32'(k - 1) : 32'h0;
            testsRun++;
            if (bus3.data_rvalid_o !== expVld || bus3.data_rdata_o !== expDat) begin
                testsFailed++;
                $display("[TB] FAIL lat3_cycle%0d got rvalid=%b rdata=%h want %b/%h",
                         k + 1, bus3.data_rvalid_o, bus3.data_rdata_o, expVld, expDat);
            end
        end
        bus3.data_req_i = 1'b0;
    endtask

    task automatic test_stall_wrap();
        bdWe = 1'b1; bdAddr = 8'd0; bdWdata = 32'h1234_5678;
        tick();
        bdWe = 1'b0;
        stall = 1'b1;
        bus1.data_req_i = 1'b1; bus1.data_we_i = 1'b0; bus1.data_addr_i = 32'h400;
        for (int c = 0; c < 4; c++) begin
            #1;
            testsRun++;
            if (bus1.data_gnt_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL stall_gnt%0d got %b want 0", c, bus1.data_gnt_o);
            end
            tick();
        end
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stall_rvalid got %b want 0", bus1.data_rvalid_o);
        end
        stall = 1'b0;
        #1;
        testsRun++;
        if (bus1.data_gnt_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL unstall_gnt got %b want 1", bus1.data_gnt_o);
        end
        tick();
        bus1.data_req_i = 1'b0;
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b1 || bus1.data_rdata_o !== 32'h1234_5678) begin
            testsFailed++;
            $display("[TB] FAIL wrap_read got rvalid=%b rdata=%h want 1/12345678", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
        tick();
    endtask

    task automatic test_clear();
        int busyCycles;
        int gntSeen;
        busyCycles = 0;
        gntSeen = 0;
        memClear = 1'b1;
        tick();
        memClear = 1'b0;
        bus1.data_req_i = 1'b1; bus1.data_we_i = 1'b0; bus1.data_addr_i = 32'h0;
        while (busy1 === 1'b1 && busyCycles < 400) begin
            #1;
            if (bus1.data_gnt_o !== 1'b0) gntSeen++;
            // Word 0 is already swept here, so this backdoor write must be ignored.
            bdWe = (busyCycles == 10); bdAddr = 8'd0; bdWdata = 32'h7777_7777;
            busyCycles++;
            tick();
        end
        bdWe = 1'b0;
        testsRun++;
        if (busyCycles !== 256) begin
            testsFailed++;
            $display("[TB] FAIL clear_busy_len got %0d want 256", busyCycles);
        end
        testsRun++;
        if (gntSeen !== 0) begin
            testsFailed++;
            $display("[TB] FAIL clear_no_gnt got %0d grants want 0", gntSeen);
        end
        tick();
        bus1.data_addr_i = 32'h3FC;
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b1 || bus1.data_rdata_o !== 32'hA5A5_A5A5) begin
            testsFailed++;
            $display("[TB] FAIL clear_word0 got rvalid=%b rdata=%h want 1/a5a5a5a5", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
        tick();
        bus1.data_req_i = 1'b0;
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b1 || bus1.data_rdata_o !== 32'hA5A5_A5A5) begin
            testsFailed++;
            $display("[TB] FAIL clear_word255 got rvalid=%b rdata=%h want 1/a5a5a5a5", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
        tick();
    endtask

    task automatic test_backdoor_collision();
        bdWe = 1'b1; bdAddr = 8'd7; bdWdata = 32'hFFFF_FFFF;
        bus1.data_req_i = 1'b1; bus1.data_we_i = 1'b1; bus1.data_addr_i = 32'h1C;
        bus1.data_be_i = 4'b0011; bus1.data_wdata_i = 32'h0000_ABCD;
        tick();
        bdWe = 1'b0;
        bus1.data_we_i = 1'b0; bus1.data_be_i = 4'hF; bus1.data_wdata_i = 32'h0;
        tick();
        testsRun++;
        if (bus1.data_rvalid_o !== 1'b1 || bus1.data_rdata_o !== 32'hFFFF_ABCD) begin
            testsFailed++;
            $display("[TB] FAIL bd_bus_write got rvalid=%b rdata=%h want 1/ffffabcd", bus1.data_rvalid_o, bus1.data_rdata_o);
        end
        bus1.data_req_i = 1'b0;
        bdWe = 1'b1; bdAddr = 8'd8; bdWdata = 32'h1111_1111;
        tick();
        bdWdata = 32'h2222_2222;
        bus1.data_req_i = 1'b1; bus1.data_addr_i = 32'h20;
        tick();
        bdWe = 1'b0;
        testsRun++;
        if (bus1.data_rdata_o !== 32'h1111_1111) begin
            testsFailed++;
            $display("[TB] FAIL bd_read_old got %h want 11111111", bus1.data_rdata_o);
        end
        tick();
        bus1.data_req_i = 1'b0;
        testsRun++;
        if (bus1.data_rdata_o !== 32'h2222_2222) begin
            testsFailed++;
            $display("[TB] FAIL bd_read_new got %h want 22222222", bus1.data_rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        int vldSeen;
        vldSeen = 0;
        bus1.data_req_i = 1'b1; bus1.data_we_i = 1'b0; bus1.data_addr_i = 32'h14;
        bus3.data_req_i = 1'b1; bus3.data_we_i = 1'b0; bus3.data_addr_i = 32'h14;
        tick();
        bus1.data_req_i = 1'b0;
        bus3.data_req_i = 1'b0;
        rst = 1'b1;
        #1;
        if (bus1.data_rvalid_o !== 1'b0 || bus3.data_rvalid_o !== 1'b0) vldSeen++;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus1.data_rvalid_o !== 1'b0 || bus3.data_rvalid_o !== 1'b0) vldSeen++;
            tick();
        end
        testsRun++;
        if (vldSeen !== 0) begin
            testsFailed++;
            $display("[TB] FAIL reset_drop got %0d cycles with rvalid want 0", vldSeen);
        end
`ifdef MEM_STATS_EN
        testsRun++;
        if (rdCount1 !== 32'h0 || rdCount3 !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL stats_reset got rd1=%0d rd3=%0d want 0/0", rdCount1, rdCount3);
        end
        bus1.data_req_i = 1'b1; bus1.data_we_i = 1'b0;
        tick();
        bus1.data_we_i = 1'b1; bus1.data_be_i = 4'h0;
        tick();
        bus1.data_req_i = 1'b0; bus1.data_we_i = 1'b0; bus1.data_be_i = 4'hF;
        testsRun++;
        if (rdCount1 !== 32'd1 || wrCount1 !== 32'd1 || rdCount3 !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL stats_count got rd1=%0d wr1=%0d rd3=%0d want 1/1/0", rdCount1, wrCount1, rdCount3);
        end
`endif
    endtask

    initial begin
        idleBuses();
        test_reset();
        test_read_basic();
        test_byte_write();
        test_back_to_back();
        test_stall_wrap();
        test_clear();
        test_backdoor_collision();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/riscy_data_mem_responder.md
Name: riscy_data_mem_responder

Overview:
- Synthesizable data-memory slave that sits directly downstream of the RISCY core's data memory port.
- Consumes the core's request signals (req, we, be, addr, wdata) and produces the responses (gnt, rvalid, rdata) in place of the hand-driven stimulus used in standalone testing.
- Word-organised RAM with byte-enable writes, a fixed-latency in-order response pipeline, grant throttling, and a backdoor preload port for benches.

Parameters:
- MEM_DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
- RVALID_LATENCY, 1, cycles from the grant edge to rvalid; range 1..8.
- INIT_VALUE, 32'h0000_0000, value written to every word by the mem_clear_i sweep.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- data_req_i  in  1  core request
- data_gnt_o  out  1  grant; request accepted this cycle
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables; bit n covers byte lane n
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  read data
- stall_i  in  1  suppresses grant while high
- bd_we_i  in  1  backdoor word write
- bd_addr_i  in  $clog2(MEM_DEPTH_WORDS)  backdoor word index
- bd_wdata_i  in  32  backdoor data
- mem_clear_i  in  1  pulse: start the INIT_VALUE sweep
- busy_o  out  1  high while the clear sweep runs

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, busy_o=0; pipeline emptied; sweep FSM returns to IDLE. RAM contents are not reset.
- Reset mid-operation: in-flight responses are dropped and no rvalid is issued for them.
- Grant (combinational): data_gnt_o = data_req_i & ~stall_i & ~busy_o & ~rst_i. There is no queue, so at most one access is granted per cycle.
- Word index: data_addr_i[$clog2(MEM_DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap modulo the depth. addr[1:0] are ignored; alignment is expressed through data_be_i.
- Write: performed at the grant edge. Only the lanes enabled in data_be_i are updated. be=4'b0000 updates nothing but still produces a response.
- Read: the word is sampled at the grant edge. The full 32-bit word is returned regardless of be.
- Response pipeline: a shift register RVALID_LATENCY deep carrying {valid, rdata}.
  - data_rvalid_o rises exactly RVALID_LATENCY cycles after the grant cycle.
  - Responses are strictly in order; back-to-back grants give back-to-back rvalids.
  - Writes also produce an rvalid, with data_rdata_o = 0.
  - When no response is valid, data_rdata_o holds 0.
- Read-after-write: a read granted on the cycle after a write to the same word returns the new data.
- Backdoor vs bus, same cycle:
  - A backdoor write to the same word is applied first and the bus write is applied over it, so enabled bus lanes win.
  - A bus read in the same cycle as a backdoor write to that word returns the old data.
- Sweep FSM: IDLE -> CLEAR on mem_clear_i, which is only accepted in IDLE.
  - CLEAR writes INIT_VALUE to one word per cycle, index 0..MEM_DEPTH_WORDS-1; busy_o=1 throughout.
  - After the last word it returns to IDLE, so busy_o lasts exactly MEM_DEPTH_WORDS cycles.
  - Responses already in flight still complete during CLEAR.
  - bd_we_i is ignored while busy_o=1.
- Simultaneous events: stall_i and data_req_i high together give no grant. The core holds its request and the grant occurs on the first cycle with stall_i=0.

Optional Feature:
- MEM_STATS_EN defined: adds outputs rd_count_o[31:0] and wr_count_o[31:0].
  - Each increments by one per granted read or write respectively, wrapping at 2^32.
  - Both reset to 0.
- MEM_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Backdoor word 5 = 32'hDEAD_BEEF; read addr 32'h14 with latency 1 -> gnt in the request cycle; rvalid one cycle later with rdata 32'hDEAD_BEEF.
- Word 3 = 32'h1122_3344; write addr 32'h0C, be=4'b0101, wdata 32'hAABB_CCDD; then read -> 32'h11BB_33DD; write rvalid carries rdata 0.
- RVALID_LATENCY=3; reads of words 0, 1, 2 on consecutive cycles (backdoor 1, 2, 3) -> rvalid high three consecutive cycles, starting 3 cycles after the first grant; data 1, 2, 3 in order.
- stall_i high for 4 cycles with req held -> gnt=0 for those 4 cycles, then one grant; read of addr 32'h400 with depth 256 returns word 0.
- mem_clear_i with INIT_VALUE=32'hA5A5_A5A5 -> busy_o high exactly 256 cycles with no grants; afterwards word 255 reads 32'hA5A5_A5A5.
- Issue a read, assert rst_i on the next cycle -> no rvalid ever appears; with MEM_STATS_EN, rd_count_o = 0 after reset.
